// File: rtl/readout_sequencer.sv
// Pixel array row readout: select a row, let it settle, latch it, then stream its pixels over valid/ready.
// Define READOUT_PREFETCH_EN to double-buffer rows and select/latch the next row while streaming.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | row select asserted, settle timer running
// LATCH  | row select asserted, row buffer captures p_data this cycle
// STREAM | one pixel per handshake from the active buffer
// WAIT   | prefetch only: row finished before the next row's latch completed
// DONE   | one-cycle done pulse
module readout_sequencer #(
    parameter int PIXEL_ARRAY_WIDTH  = 4,
    parameter int PIXEL_ARRAY_HEIGHT = 4,
    parameter int PIXEL_BITS         = 8,
    parameter int SETTLE_CYCLES      = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]            p_row_select,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]  p_data,
    output logic [PIXEL_BITS-1:0]                    out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_sof,
    output logic                                     out_eol,
    output logic                                     out_eof
);

    localparam int W  = PIXEL_ARRAY_WIDTH;
    localparam int H  = PIXEL_ARRAY_HEIGHT;
    localparam int PB = PIXEL_BITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(H - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [H-1:0]  ROW_ONE     = H'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_LATCH, S_STREAM, S_DONE, S_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [SW-1:0] st_cnt_q, st_cnt_d;
    logic          handshake, last_col, last_row;

    assign handshake = (state_q == S_STREAM) && out_ready;
    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);

`ifdef READOUT_PREFETCH_EN
    localparam logic [SW-1:0] PF_LOAD = SW'(SETTLE_CYCLES);

    logic [PB-1:0] buf_q [2][W];
    logic          rd_sel_q, rd_sel_d;
    logic          pf_active_q, pf_active_d;
    logic          pf_full_q, pf_full_d;
    logic [SW-1:0] pf_cnt_q, pf_cnt_d;
    logic          pf_latch, pf_ready, pf_swap;

    // pf_cnt reaching zero is the latch cycle: row select still held, idle buffer captures at its end
    assign pf_latch = pf_active_q && (pf_cnt_q == '0);
    assign pf_ready = pf_full_q || pf_latch;
    assign pf_swap  = pf_ready && ((state_q == S_WAIT) ||
                      (handshake && last_col && !last_row));
`else
    logic [PB-1:0] buf_q [W];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            st_cnt_q    <= '0;
`ifdef READOUT_PREFETCH_EN
            rd_sel_q    <= 1'b0;
            pf_active_q <= 1'b0;
            pf_full_q   <= 1'b0;
            pf_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            st_cnt_q    <= st_cnt_d;
`ifdef READOUT_PREFETCH_EN
            rd_sel_q    <= rd_sel_d;
            pf_active_q <= pf_active_d;
            pf_full_q   <= pf_full_d;
            pf_cnt_q    <= pf_cnt_d;
`endif
        end
    end

    // Row buffers hold no control state, so they are left unreset
    always_ff @(posedge clk) begin
`ifdef READOUT_PREFETCH_EN
        if (state_q == S_LATCH) begin
            for (int c = 0; c < W; c++) buf_q[rd_sel_q][c] <= p_data[c*PB +: PB];
        end
        if (pf_latch) begin
            for (int c = 0; c < W; c++) buf_q[~rd_sel_q][c] <= p_data[c*PB +: PB];
        end
`else
        if (state_q == S_LATCH) begin
            for (int c = 0; c < W; c++) buf_q[c] <= p_data[c*PB +: PB];
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        st_cnt_d = st_cnt_q;
`ifdef READOUT_PREFETCH_EN
        rd_sel_d    = rd_sel_q;
        pf_active_d = pf_active_q;
        pf_full_d   = pf_full_q;
        pf_cnt_d    = pf_cnt_q;
        if (pf_active_q) begin
            if (pf_latch) begin
                pf_active_d = 1'b0;
                pf_full_d   = 1'b1;
            end else begin
                pf_cnt_d = pf_cnt_q - 1'b1;
            end
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SELECT;
                    row_d    = '0;
                    col_d    = '0;
                    st_cnt_d = SETTLE_LOAD;
                end
            end
            S_SELECT: begin
                if (st_cnt_q == '0) state_d = S_LATCH;
                else                st_cnt_d = st_cnt_q - 1'b1;
            end
            S_LATCH: begin
                state_d = S_STREAM;
                col_d   = '0;
`ifdef READOUT_PREFETCH_EN
                if (!last_row) begin
                    pf_active_d = 1'b1;
                    pf_cnt_d    = PF_LOAD;
                    pf_full_d   = 1'b0;
                end
`endif
            end
            S_STREAM: begin
                if (handshake) begin
                    if (!last_col) begin
                        col_d = col_q + 1'b1;
                    end else if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        col_d = '0;
`ifdef READOUT_PREFETCH_EN
                        state_d = S_WAIT;
`else
                        state_d  = S_SELECT;
                        row_d    = row_q + 1'b1;
                        st_cnt_d = SETTLE_LOAD;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_WAIT: begin
`ifndef READOUT_PREFETCH_EN
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
`ifdef READOUT_PREFETCH_EN
        // Next row already in the idle buffer: swap and keep streaming, re-arm prefetch for the row after
        if (pf_swap) begin
            state_d   = S_STREAM;
            row_d     = row_q + 1'b1;
            col_d     = '0;
            rd_sel_d  = ~rd_sel_q;
            pf_full_d = 1'b0;
            if ((row_q + RW'(1)) != ROW_LAST) begin
                pf_active_d = 1'b1;
                pf_cnt_d    = PF_LOAD;
            end
        end
`endif
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        p_row_select = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_sof      = 1'b0;
        out_eol      = 1'b0;
        out_eof      = 1'b0;
        if ((state_q == S_SELECT) || (state_q == S_LATCH)) begin
            p_row_select = ROW_ONE << row_q;
        end
        if (state_q == S_STREAM) begin
            out_valid = 1'b1;
`ifdef READOUT_PREFETCH_EN
            out_data  = buf_q[rd_sel_q][col_q];
`else
            out_data  = buf_q[col_q];
`endif
            out_sof   = (row_q == '0) && (col_q == '0);
            out_eol   = last_col;
            out_eof   = last_col && last_row;
        end
`ifdef READOUT_PREFETCH_EN
        if (((state_q == S_STREAM) || (state_q == S_WAIT)) && pf_active_q) begin
            p_row_select = ROW_ONE << (row_q + RW'(1));
        end
`endif
    end

endmodule
